// File: rtl/product_assembler_pkg.sv
// Shared FPU definitions for the mantissa product assembler: partial-product
// alignment codes, FSM state encoding and datapath sizes.
package product_assembler_pkg;

  localparam int PP_COUNT  = 4;
  localparam int ACC_WIDTH = 48;

  // Counter value at which the final partial product is accepted
  localparam logic [2:0] PP_LAST = 3'(PP_COUNT - 1);

  // pp_shift_in encodings; the fourth code (3) is invalid and contributes zero
  localparam logic [1:0] PP_SHIFT_0  = 2'd0;
  localparam logic [1:0] PP_SHIFT_16 = 2'd1;
  localparam logic [1:0] PP_SHIFT_32 = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_NORM  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Place a 32-bit partial product at its weight inside the 48-bit accumulator.
  // Bits pushed beyond bit 47 are dropped, giving modulo-2^48 addition.
  function automatic logic [ACC_WIDTH-1:0] align_pp(input logic [31:0] pp,
                                                     input logic [1:0]  code);
    logic [ACC_WIDTH-1:0] aligned;
    case (code)
      PP_SHIFT_0:  aligned = {16'd0, pp};
      PP_SHIFT_16: aligned = {pp, 16'd0};
      PP_SHIFT_32: aligned = {pp[15:0], 32'd0};
      default:     aligned = 48'd0;
    endcase
    return aligned;
  endfunction

endpackage

// File: rtl/product_assembler_normalizer.sv
// product_normalizer: combinational normalization of a 48-bit mantissa
// product into a 24-bit mantissa (hidden bit at [23]) plus guard/round/sticky.
// Macro FPU_GRS_EN: when defined, guard/round/sticky are computed; otherwise
// they are tied to 0 (truncation mode) and no sticky OR-tree is built.
module product_normalizer
  import product_assembler_pkg::*;
(
  input  logic [ACC_WIDTH-1:0] acc_in,
  output logic [23:0]          mantissa_out,
  output logic                 norm_shift_out,
  output logic                 guard_out,
  output logic                 round_out,
  output logic                 sticky_out
);

  // Product in [2.0, 4.0) has its leading one at bit 47; otherwise at bit 46
  always_comb begin
    norm_shift_out = acc_in[47];
    if (acc_in[47]) begin
      mantissa_out = acc_in[47:24];
    end else begin
      mantissa_out = acc_in[46:23];
    end
  end

`ifdef FPU_GRS_EN
  // Rounding bits sit directly below the selected mantissa window
  always_comb begin
    if (acc_in[47]) begin
      guard_out  = acc_in[23];
      round_out  = acc_in[22];
      sticky_out = |acc_in[21:0];
    end else begin
      guard_out  = acc_in[22];
      round_out  = acc_in[21];
      sticky_out = |acc_in[20:0];
    end
  end
`else
  // Truncation mode: low product bits are discarded
  logic unused_low_s;
  assign unused_low_s = ^acc_in[22:0];

  // Rounding information is not produced in truncation mode
  always_comb begin
    guard_out  = 1'b0;
    round_out  = 1'b0;
    sticky_out = 1'b0;
  end
`endif

endmodule

// File: rtl/product_assembler.sv
// product_assembler: accumulates four aligned 16x16 partial products into a
// 48-bit 24x24 mantissa product, then normalizes it and presents registered
// mantissa/GRS results with a one-cycle done pulse.
// Macro FPU_GRS_EN enables guard/round/sticky outputs (see product_normalizer).
module product_assembler
  import product_assembler_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start_in,
  input  logic        pp_valid_in,
  input  logic [1:0]  pp_shift_in,
  input  logic [31:0] pp_in,
  output logic        busy_out,
  output logic        done_out,
  output logic [23:0] mantissa_out,
  output logic        norm_shift_out,
  output logic        guard_out,
  output logic        round_out,
  output logic        sticky_out
);

  state_e               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [2:0]           cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [23:0]          mant_q, mant_d;
  logic                 norm_q, norm_d;
  logic                 guard_q, guard_d;
  logic                 round_q, round_d;
  logic                 sticky_q, sticky_d;

  logic [23:0] nrm_mant_s;
  logic        nrm_norm_s;
  logic        nrm_guard_s;
  logic        nrm_round_s;
  logic        nrm_sticky_s;

  product_normalizer u_normalizer (
    .acc_in         (acc_q),
    .mantissa_out   (nrm_mant_s),
    .norm_shift_out (nrm_norm_s),
    .guard_out      (nrm_guard_s),
    .round_out      (nrm_round_s),
    .sticky_out     (nrm_sticky_s)
  );

  // Next-state, accumulation and result-capture logic
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    mant_d   = mant_q;
    norm_d   = norm_q;
    guard_d  = guard_q;
    round_d  = round_q;
    sticky_d = sticky_q;
    case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          state_d = ST_ACCUM;
          acc_d   = 48'd0;
          cnt_d   = 3'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (pp_valid_in) begin
          acc_d = acc_q + align_pp(pp_in, pp_shift_in);
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == PP_LAST) begin
            state_d = ST_NORM;
          end else begin
            state_d = ST_ACCUM;
          end
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_NORM: begin
        state_d  = ST_DONE;
        mant_d   = nrm_mant_s;
        norm_d   = nrm_norm_s;
        guard_d  = nrm_guard_s;
        round_d  = nrm_round_s;
        sticky_d = nrm_sticky_s;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State, datapath and registered-output flops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      acc_q    <= 48'd0;
      cnt_q    <= 3'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mant_q   <= 24'd0;
      norm_q   <= 1'b0;
      guard_q  <= 1'b0;
      round_q  <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      mant_q   <= mant_d;
      norm_q   <= norm_d;
      guard_q  <= guard_d;
      round_q  <= round_d;
      sticky_q <= sticky_d;
    end
  end

  assign busy_out       = busy_q;
  assign done_out       = done_q;
  assign mantissa_out   = mant_q;
  assign norm_shift_out = norm_q;
  assign guard_out      = guard_q;
  assign round_out      = round_q;
  assign sticky_out     = sticky_q;

endmodule

// File: tb/tb_product_assembler.sv
// Self-checking bench for product_assembler: an arithmetic reference model
// compared every cycle, plus directed scenarios with hand-computed results.
module tb_product_assembler;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_in;
  logic        pp_valid_in;
  logic [1:0]  pp_shift_in;
  logic [31:0] pp_in;
  logic        busy_out;
  logic        done_out;
  logic [23:0] mantissa_out;
  logic        norm_shift_out;
  logic        guard_out;
  logic        round_out;
  logic        sticky_out;

  product_assembler dut (
    .clk            (clk),
    .reset          (reset),
    .start_in       (start_in),
    .pp_valid_in    (pp_valid_in),
    .pp_shift_in    (pp_shift_in),
    .pp_in          (pp_in),
    .busy_out       (busy_out),
    .done_out       (done_out),
    .mantissa_out   (mantissa_out),
    .norm_shift_out (norm_shift_out),
    .guard_out      (guard_out),
    .round_out      (round_out),
    .sticky_out     (sticky_out)
  );

  always #5 clk = ~clk;

`ifdef FPU_GRS_EN
  localparam bit GRS_ON = 1'b1;
`else
  localparam bit GRS_ON = 1'b0;
`endif

  localparam longint unsigned ACC_MOD = 64'h1_0000_0000_0000;
  localparam longint unsigned TWO_47  = 64'h8000_0000_0000;
  localparam longint unsigned TWO_24  = 64'd16777216;
  localparam longint unsigned TWO_23  = 64'd8388608;
  localparam longint unsigned TWO_22  = 64'd4194304;
  localparam longint unsigned TWO_21  = 64'd2097152;

  int n_checks = 0;
  int n_fail   = 0;
  int done_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Weight of one partial product: value * 65536^code, invalid code weighs 0
  function automatic longint unsigned contrib(input logic [31:0] v, input logic [1:0] code);
    longint unsigned w;
    if (code == 2'd3) return 64'd0;
    w = 64'd1;
    for (int k = 0; k < int'(code); k++) w = w * 64'd65536;
    return ({32'd0, v} * w) % ACC_MOD;
  endfunction

  // ---------------- reference model ----------------
  bit              m_active;
  int              m_cnt;
  longint unsigned m_sum;
  int              m_wait;
  bit              e_done;
  logic [23:0]     e_mant;
  bit              e_ns, e_g, e_r, e_s;

  // Abstract model: operation in flight, sum of accepted products, phase after the 4th
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active <= 1'b0; m_cnt <= 0; m_sum <= 64'd0; m_wait <= 0;
      e_done <= 1'b0; e_mant <= 24'd0; e_ns <= 1'b0;
      e_g <= 1'b0; e_r <= 1'b0; e_s <= 1'b0;
    end else begin
      e_done <= 1'b0;
      if (!m_active) begin
        if (start_in) begin
          m_active <= 1'b1; m_cnt <= 0; m_sum <= 64'd0;
        end
      end else if (m_cnt < 4) begin
        if (pp_valid_in) begin
          m_sum <= (m_sum + contrib(pp_in, pp_shift_in)) % ACC_MOD;
          m_cnt <= m_cnt + 1;
        end
      end else if (m_wait == 0) begin
        m_wait <= 1;
        e_done <= 1'b1;
        if (m_sum >= TWO_47) begin
          e_ns   <= 1'b1;
          e_mant <= 24'(m_sum / TWO_24);
          e_g    <= GRS_ON && ((m_sum / TWO_23) % 2 == 1);
          e_r    <= GRS_ON && ((m_sum / TWO_22) % 2 == 1);
          e_s    <= GRS_ON && ((m_sum % TWO_22) != 0);
        end else begin
          e_ns   <= 1'b0;
          e_mant <= 24'(m_sum / TWO_23);
          e_g    <= GRS_ON && ((m_sum / TWO_22) % 2 == 1);
          e_r    <= GRS_ON && ((m_sum / TWO_21) % 2 == 1);
          e_s    <= GRS_ON && ((m_sum % TWO_21) != 0);
        end
      end else begin
        m_active <= 1'b0;
        m_wait   <= 0;
      end
    end
  end

  // Compare every output against the model on the falling edge
  always @(negedge clk) begin
    check("busy",   {63'd0, busy_out},       {63'd0, m_active});
    check("done",   {63'd0, done_out},       {63'd0, e_done});
    check("mant",   {40'd0, mantissa_out},   {40'd0, e_mant});
    check("norm",   {63'd0, norm_shift_out}, {63'd0, e_ns});
    check("guard",  {63'd0, guard_out},      {63'd0, e_g});
    check("round",  {63'd0, round_out},      {63'd0, e_r});
    check("sticky", {63'd0, sticky_out},     {63'd0, e_s});
    if (done_out) done_seen++;
  end

  // ---------------- directed stimulus ----------------
  logic [31:0] vv [4];
  logic [1:0]  ss [4];

  task automatic send_pp(input logic [31:0] v, input logic [1:0] c);
    pp_valid_in = 1'b1; pp_in = v; pp_shift_in = c;
    @(negedge clk);
    pp_valid_in = 1'b0; pp_in = 32'd0; pp_shift_in = 2'd0;
  endtask

  // Start, feed vv/ss with 'gap' idle cycles before each, pin the done latency
  task automatic run_op(input int gap, input string tag);
    start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      repeat (gap) @(negedge clk);
      send_pp(vv[i], ss[i]);
    end
    check({tag, "_lat1_done"}, {63'd0, done_out}, 64'd0);
    check({tag, "_lat1_busy"}, {63'd0, busy_out}, 64'd1);
    @(negedge clk);
    check({tag, "_lat2_done"}, {63'd0, done_out}, 64'd1);
  endtask

  task automatic check_res(input string tag, input logic [23:0] m, input bit ns,
                           input bit g, input bit r, input bit s);
    check({tag, "_mant"},   {40'd0, mantissa_out},   {40'd0, m});
    check({tag, "_norm"},   {63'd0, norm_shift_out}, {63'd0, ns});
    check({tag, "_guard"},  {63'd0, guard_out},      {63'd0, g});
    check({tag, "_round"},  {63'd0, round_out},      {63'd0, r});
    check({tag, "_sticky"}, {63'd0, sticky_out},     {63'd0, s});
  endtask

  task automatic load_ones(input bit rev);
    logic [31:0] v [4];
    logic [1:0]  c [4];
    v[0] = 32'hFFFE0001; c[0] = 2'd0;
    v[1] = 32'h00FEFF01; c[1] = 2'd1;
    v[2] = 32'h00FEFF01; c[2] = 2'd1;
    v[3] = 32'h0000FE01; c[3] = 2'd2;
    for (int i = 0; i < 4; i++) begin
      vv[i] = rev ? v[3-i] : v[i];
      ss[i] = rev ? c[3-i] : c[i];
    end
  endtask

  int snap;

  initial begin
    reset = 1'b1; start_in = 1'b0; pp_valid_in = 1'b0;
    pp_shift_in = 2'd0; pp_in = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_busy", {63'd0, busy_out}, 64'd0);
    check("rst_mant", {40'd0, mantissa_out}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Partial product offered in IDLE must be ignored
    send_pp(32'hFFFFFFFF, 2'd0);
    check("idle_busy", {63'd0, busy_out}, 64'd0);

    // 1.0 x 1.0
    vv[0] = 32'd0; ss[0] = 2'd0; vv[1] = 32'd0; ss[1] = 2'd1;
    vv[2] = 32'd0; ss[2] = 2'd1; vv[3] = 32'h4000; ss[3] = 2'd2;
    run_op(0, "one");
    check_res("one", 24'h800000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    // 0xFFFFFF squared
    load_ones(1'b0);
    run_op(0, "max");
    check_res("max", 24'hFFFFFE, 1'b1, 1'b0, 1'b0, GRS_ON);
    @(negedge clk);

    // Reverse order with idle gaps
    load_ones(1'b1);
    run_op(2, "rev");
    check_res("rev", 24'hFFFFFE, 1'b1, 1'b0, 1'b0, GRS_ON);
    @(negedge clk);

    // start/pp pulses during ACCUM, NORM and DONE
    snap = done_seen;
    start_in = 1'b1;
    @(negedge clk);
    send_pp(32'hFFFE0001, 2'd0);
    start_in = 1'b0;
    send_pp(32'h00FEFF01, 2'd1);
    send_pp(32'h00FEFF01, 2'd1);
    start_in = 1'b1;
    send_pp(32'h0000FE01, 2'd2);
    pp_valid_in = 1'b1; pp_in = 32'hFFFFFFFF; pp_shift_in = 2'd0;
    @(negedge clk);
    check("busy_done", {63'd0, done_out}, 64'd1);
    check_res("busy", 24'hFFFFFE, 1'b1, 1'b0, 1'b0, GRS_ON);
    @(negedge clk);
    start_in = 1'b0; pp_valid_in = 1'b0; pp_in = 32'd0;
    check("busy_idle", {63'd0, busy_out}, 64'd0);
    repeat (2) @(negedge clk);
    check("busy_pulses", done_seen - snap, 1);

    // Reset abort after the 2nd partial product
    start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    send_pp(32'h4000, 2'd2);
    send_pp(32'd0, 2'd0);
    #2 reset = 1'b1;
    #1;
    check("abort_busy", {63'd0, busy_out}, 64'd0);
    check("abort_done", {63'd0, done_out}, 64'd0);
    check_res("abort", 24'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    snap = done_seen;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_pulses", done_seen - snap, 0);
    load_ones(1'b0);
    run_op(1, "post");
    check_res("post", 24'hFFFFFE, 1'b1, 1'b0, 1'b0, GRS_ON);
    @(negedge clk);

    // Invalid code counts but contributes nothing
    vv[0] = 32'h4000; ss[0] = 2'd2; vv[1] = 32'hFFFFFFFF; ss[1] = 2'd3;
    vv[2] = 32'd0;    ss[2] = 2'd0; vv[3] = 32'd0;        ss[3] = 2'd1;
    run_op(0, "inv");
    check_res("inv", 24'h800000, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);

    check("total_pulses", done_seen, 6);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/product_assembler.md
PRODUCT_ASSEMBLER -- requirements
Module: product_assembler

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
REQ-002 The block SHALL have the following other ports:
- start_in  input  1  begin new 24x24 mantissa product; clears the accumulator
- pp_valid_in  input  1  partial product present this cycle
- pp_shift_in  input  2  alignment code of pp_in: 0 = <<0, 1 = <<16, 2 = <<32, 3 = invalid
- pp_in  input  32  16x16 partial product from shared multiplier
- busy_out  output  1  high whenever state is not IDLE
- done_out  output  1  one-cycle pulse; result outputs valid
- mantissa_out  output  24  normalized product mantissa, hidden bit at [23]
- norm_shift_out  output  1  product was >= 2.0; exponent must be incremented by 1
- guard_out  output  1  guard bit
- round_out  output  1  round bit
- sticky_out  output  1  OR of all bits below round

Function
REQ-003 The FSM SHALL have states IDLE, ACCUM, NORM and DONE.
REQ-004 IDLE + start_in -> ACCUM; accumulator (48 bits) and pp counter (3 bits) are cleared on the same edge.
REQ-005 In IDLE, pp_valid_in SHALL be ignored.
REQ-006 Each ACCUM cycle with pp_valid_in SHALL:
- add zero-extended pp_in shifted by 16*pp_shift_in to the accumulator, modulo 2^48;
- increment the pp counter.
REQ-007 pp_shift_in = 3 SHALL contribute zero but SHALL still count as an accepted partial product.
REQ-008 When the 4th partial product is accepted, the next state SHALL be NORM; accepted cycles need not be consecutive.
REQ-009 NORM SHALL register the outputs from the final accumulator value, then go to DONE.
REQ-010 If acc[47] = 1:
- mantissa_out = acc[47:24], guard_out = acc[23], round_out = acc[22];
- sticky_out = |acc[21:0]; norm_shift_out = 1.
REQ-011 If acc[47] = 0:
- mantissa_out = acc[46:23], guard_out = acc[22], round_out = acc[21];
- sticky_out = |acc[20:0]; norm_shift_out = 0.
REQ-012 DONE SHALL assert done_out for exactly one cycle, then go to IDLE.
- Latency: done_out is high 2 cycles after the edge that accepts the 4th partial product.
REQ-013 Result outputs SHALL hold their values until the next NORM.
REQ-014 start_in while busy_out = 1 SHALL be ignored.
REQ-015 start_in in DONE SHALL be ignored; start_in is accepted again from the first IDLE cycle.
REQ-016 Partial products arriving in NORM or DONE SHALL be ignored and not counted.
REQ-017 Partial products are order-independent; any order of the four SHALL give the same result.

Reset
REQ-018 Reset SHALL immediately force:
- state IDLE, accumulator 0, counter 0;
- busy_out 0, done_out 0, mantissa_out 0, norm_shift_out 0, guard_out 0, round_out 0, sticky_out 0.
REQ-019 Reset during ACCUM, NORM or DONE SHALL abort the operation; no done_out pulse follows.

Configuration
REQ-020 The block SHALL support macro FPU_GRS_EN.
- Defined: guard_out, round_out and sticky_out are computed per REQ-010/REQ-011.
- Undefined: guard_out, round_out and sticky_out are constant 0 (truncation mode); the sticky OR-reduction logic is not built.
- mantissa_out and norm_shift_out are identical in both modes.

Structure
REQ-021 The shared FPU package SHALL hold:
- the pp_shift_in encodings (PP_SHIFT_0, PP_SHIFT_16, PP_SHIFT_32);
- the FSM state encoding;
- PP_COUNT = 4 and ACC_WIDTH = 48.
REQ-022 Normalization and GRS extraction SHALL be one combinational sub-module, product_normalizer (48-bit in; mantissa/norm/GRS out).

Verification
REQ-023 1.0 x 1.0: start; four partial products (0, shift 0), (0, shift 16), (0, shift 16), (0x4000, shift 32) -> mantissa_out 0x800000, norm_shift_out 0, GRS 000.
REQ-024 0xFFFFFF x 0xFFFFFF: partial products (0xFFFE0001, 0), (0xFEFF01, 1), (0xFEFF01, 1), (0xFE01, 2) -> accumulator 0xFFFFFE000001, mantissa_out 0xFFFFFE, norm_shift_out 1, guard_out 0, round_out 0, sticky_out 1 (0 without FPU_GRS_EN).
REQ-025 Same four partial products in reverse order with idle gaps between them -> identical result; done_out exactly 2 cycles after the 4th accepted partial product.
REQ-026 start_in and pp_valid_in pulsed during ACCUM/NORM/DONE:
- no restart;
- the extra partial product in NORM is not added;
- exactly one done_out pulse.
REQ-027 Reset asserted after the 2nd partial product -> all outputs 0 immediately; no done_out pulse; a following full sequence gives a correct result.
REQ-028 A partial product with pp_shift_in = 3 and value 0xFFFFFFFF -> counted, contributes 0; the 4th valid-flagged partial product triggers NORM.
